// File: rtl/mips_pkg.sv
// Shared definitions for the mips_mc multi-cycle accumulator core.
// Holds opcode constants, FSM state encoding, instruction geometry and a
// signed-overflow helper used by the ALU.
package mips_pkg;

  // Instruction word: opcode in [8:6], operand field in [5:0]
  localparam int IW          = 9;
  localparam int OP_MSB      = 8;
  localparam int OP_LSB      = 6;
  localparam int FLD_MSB     = 5;
  localparam int FLD_LSB     = 0;
  localparam int MOV_DIR_BIT = 3;   // MOV: 0 = R <- acc, 1 = acc <- R

  // Register file geometry
  localparam int NREG = 8;
  localparam int RAW  = 3;

  localparam logic [2:0] OP_LDI  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MOV  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_BZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Signed overflow from operand and result sign bits. For SUB the second
  // operand is effectively negated, so overflow needs differing signs.
  function automatic logic sgn_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb, input logic is_sub);
    if (is_sub) return (a_msb != b_msb) && (r_msb != a_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 8 x DW register file: one asynchronous read port, one synchronous write port.
// Ports: clk, rst (async active-low, clears all registers), raddr/rdata,
//        we/waddr/wdata.
// Latency: read combinational, write visible the cycle after we.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RAW-1:0] raddr,
  output logic [DW-1:0]  rdata,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [DW-1:0]  wdata
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/mips_mc.sv
// mips_mc: multi-cycle accumulator core, FETCH -> EXEC (-> MEM) per instruction.
// Latency: 2 cycles ALU/MOV/BZ/HALT, 3 cycles LD/ST with zero-wait memories;
//          FETCH and MEM stall (outputs held) until imem_valid / dmem_valid.
// Ports: clk, rst (async active-low), imem_req/addr/valid/inst,
//        dmem_req/we/addr/wdata/valid/rdata, acc_out, overflow (sticky), halted.
// Option: define MIPS_MC_OVF_TRAP_EN to halt after a signed-overflowing ADD/SUB.
module mips_mc
  import mips_pkg::*;
#(
  parameter int DW  = 8,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_valid,
  input  logic [IW-1:0]  imem_inst,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [PCW-1:0] dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_valid,
  input  logic [DW-1:0]  dmem_rdata,
  output logic [DW-1:0]  acc_out,
  output logic           overflow,
  output logic           halted
);

  state_t         state, state_n;
  logic [PCW-1:0] pc, pc_n;
  logic [DW-1:0]  acc, acc_n;
  logic [IW-1:0]  inst, inst_n;
  logic           ovf_q, ovf_n;

  logic [2:0]         opcode;
  logic [FLD_MSB:0]   field;
  logic [RAW-1:0]     rsel;
  logic [DW-1:0]      rf_rdata;
  logic               rf_we;
  logic [DW-1:0]      sum, diff;
  logic               add_ovf, sub_ovf;

  assign opcode = inst[OP_MSB:OP_LSB];
  assign field  = inst[FLD_MSB:FLD_LSB];
  assign rsel   = field[RAW-1:0];

  mips_regfile #(.DW(DW)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .raddr (rsel),
    .rdata (rf_rdata),
    .we    (rf_we),
    .waddr (rsel),
    .wdata (acc)
  );

  assign sum     = acc + rf_rdata;
  assign diff    = acc - rf_rdata;
  assign add_ovf = sgn_ovf(acc[DW-1], rf_rdata[DW-1], sum[DW-1], 1'b0);
  assign sub_ovf = sgn_ovf(acc[DW-1], rf_rdata[DW-1], diff[DW-1], 1'b1);

  // Requests are gated by rst so they drop the instant reset asserts, even
  // in the middle of a stalled memory access.
  assign imem_req   = rst && (state == ST_FETCH);
  assign dmem_req   = rst && (state == ST_MEM);
  assign dmem_we    = dmem_req && (opcode == OP_ST);
  assign imem_addr  = pc;
  // inst, regs and acc cannot change while in MEM, so these stay stable
  // across any number of wait cycles. The cast truncates or zero-extends.
  assign dmem_addr  = PCW'(rf_rdata);
  assign dmem_wdata = acc;

  assign acc_out  = acc;
  assign overflow = ovf_q;
  assign halted   = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_FETCH;
      pc    <= '0;
      acc   <= '0;
      inst  <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      acc   <= acc_n;
      inst  <= inst_n;
      ovf_q <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    acc_n   = acc;
    inst_n  = inst;
    ovf_n   = ovf_q;
    rf_we   = 1'b0;

    case (state)
      ST_FETCH: begin
        if (imem_valid) begin
          inst_n  = imem_inst;
          pc_n    = pc + 1'b1;
          state_n = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_n = ST_FETCH;
        case (opcode)
          OP_LDI: acc_n = DW'($signed(field));
          OP_ADD: begin
            acc_n = sum;
            if (add_ovf) begin
              ovf_n = 1'b1;
`ifdef MIPS_MC_OVF_TRAP_EN
              state_n = ST_HALT;
`endif
            end
          end
          OP_SUB: begin
            acc_n = diff;
            if (sub_ovf) begin
              ovf_n = 1'b1;
`ifdef MIPS_MC_OVF_TRAP_EN
              state_n = ST_HALT;
`endif
            end
          end
          OP_MOV: begin
            if (field[MOV_DIR_BIT]) acc_n = rf_rdata;
            else                    rf_we = 1'b1;
          end
          OP_LD, OP_ST: state_n = ST_MEM;
          // pc already points past the BZ, so the offset is relative to it
          OP_BZ: begin
            if (acc == '0) pc_n = pc + PCW'($signed(field));
          end
          OP_HALT: state_n = ST_HALT;
          default: state_n = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        if (dmem_valid) begin
          if (opcode == OP_LD) acc_n = dmem_rdata;
          state_n = ST_FETCH;
        end
      end

      ST_HALT: state_n = ST_HALT;

      default: state_n = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc.sv
// Self-checking bench for mips_mc: directed program table, hand-written
// corner sequences (branch wrap, reset during a stalled store) and random
// programs checked against an instruction-level reference model.
module tb_mips_mc;

  localparam int DW  = 8;
  localparam int PCW = 8;

  logic           clk, rst;
  logic           imem_req, imem_valid;
  logic [PCW-1:0] imem_addr;
  logic [8:0]     imem_inst;
  logic           dmem_req, dmem_we, dmem_valid;
  logic [PCW-1:0] dmem_addr;
  logic [DW-1:0]  dmem_wdata, dmem_rdata;
  logic [DW-1:0]  acc_out;
  logic           overflow, halted;

  mips_mc #(.DW(DW), .PCW(PCW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_inst(imem_inst),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata),
    .acc_out(acc_out), .overflow(overflow), .halted(halted)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] enc(input logic [2:0] op, input int f);
    return {op, 6'(f)};
  endfunction

  // ---------------- memories and protocol monitor ----------------
  logic [8:0] imem   [256];
  logic [7:0] dmem   [256];
  logic [7:0] m_dmem [256];
  int imem_wait = 0, dmem_wait = 0;
  int viol_overlap = 0, viol_stable = 0, st_count = 0;
  logic [7:0] st_addr, st_data;

  int icnt, dcnt;
  logic p_ireq, p_ival, p_dreq, p_dval, p_dwe;
  logic [7:0] p_iaddr, p_daddr, p_dwd;

  initial begin
    imem_valid = 0; imem_inst = '0; dmem_valid = 0; dmem_rdata = '0;
    icnt = 0; dcnt = 0;
    p_ireq = 0; p_ival = 0; p_dreq = 0; p_dval = 0; p_dwe = 0;
    p_iaddr = '0; p_daddr = '0; p_dwd = '0;
    forever begin
      @(negedge clk);
      if (imem_req && dmem_req) viol_overlap++;
      if (dmem_we && !dmem_req) viol_overlap++;
      if (rst && p_ireq && !p_ival && (!imem_req || imem_addr !== p_iaddr)) viol_stable++;
      if (rst && p_dreq && !p_dval &&
          (!dmem_req || dmem_addr !== p_daddr || dmem_we !== p_dwe || dmem_wdata !== p_dwd))
        viol_stable++;
      if (imem_req) begin
        imem_inst  = imem[imem_addr];
        imem_valid = (icnt >= imem_wait);
        icnt++;
      end else begin
        imem_valid = 0; icnt = 0;
      end
      if (dmem_req) begin
        dmem_rdata = dmem[dmem_addr];
        dmem_valid = (dcnt >= dmem_wait);
        if (dmem_valid && dmem_we) begin
          dmem[dmem_addr] = dmem_wdata;
          st_addr = dmem_addr; st_data = dmem_wdata; st_count++;
        end
        dcnt++;
      end else begin
        dmem_valid = 0; dcnt = 0;
      end
      p_ireq = imem_req; p_ival = imem_valid; p_iaddr = imem_addr;
      p_dreq = dmem_req; p_dval = dmem_valid; p_daddr = dmem_addr;
      p_dwe = dmem_we; p_dwd = dmem_wdata;
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = enc(3'b111, 0);
  endtask

  // Reset is released just after a rising edge so the next falling-edge
  // responder already sees the first fetch request.
  task automatic do_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    viol_overlap = 0; viol_stable = 0; st_count = 0;
    rst = 1;
  endtask

  task automatic run(input int budget, output int cyc, output bit ok);
    cyc = 0; ok = 0;
    while (cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (halted) begin ok = 1; break; end
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic int sg(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model(input int iw, input int dw, output int macc, output int mpc,
                       output int movf, output int mhalt, output int mcyc);
    int r[8];
    int acc, pc, ovf, cyc, op, f, v, s, rs, steps;
    bit done;
    for (int i = 0; i < 8; i++) r[i] = 0;
    acc = 0; pc = 0; ovf = 0; cyc = 0; done = 0; steps = 0;
    while (!done && steps < 2000) begin
      op = int'(imem[pc][8:6]);
      f  = int'(imem[pc][5:0]);
      v  = (f >= 32) ? f - 64 : f;
      rs = f % 8;
      pc = (pc + 1) % 256;
      cyc += 2 + iw;
      steps++;
      case (op)
        0: acc = v & 255;
        1, 2: begin
          s   = (op == 1) ? sg(acc) + sg(r[rs]) : sg(acc) - sg(r[rs]);
          acc = s & 255;
          if (s > 127 || s < -128) begin
            ovf = 1;
`ifdef MIPS_MC_OVF_TRAP_EN
            done = 1;
`endif
          end
        end
        3: if (((f >> 3) & 1) == 1) acc = r[rs]; else r[rs] = acc;
        4: begin cyc += 1 + dw; acc = int'(m_dmem[r[rs]]); end
        5: begin cyc += 1 + dw; m_dmem[r[rs]] = 8'(acc); end
        6: if (acc == 0) pc = (pc + v + 256) % 256;
        default: done = 1;
      endcase
    end
    macc = acc; mpc = pc; movf = ovf; mhalt = done; mcyc = cyc;
  endtask

  // ---------------- directed program table ----------------
  typedef struct {
    logic [11:0][8:0] prog;
    int iw;
    int dwt;
    logic [7:0] acc;
    logic [7:0] pc;
    logic ovf;
    int cyc;
    bit is_mem;
  } vec_t;

  vec_t vt[7];

  initial begin
    int cyc, mm, macc, mpc, movf, mhalt, mcyc, r;
    bit ok;
    logic [7:0] a0, p0;

    rst = 0;
    // directed table
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 12; j++) vt[k].prog[j] = enc(3'b111, 0);
      vt[k].iw = 0; vt[k].dwt = 0; vt[k].ovf = 0; vt[k].is_mem = 0;
    end
    // LDI 5; MOV R1<-acc; LDI 3; ADD R1; HALT
    for (int k = 0; k < 2; k++) begin
      vt[k].prog[0] = enc(3'b000, 5); vt[k].prog[1] = enc(3'b011, 1);
      vt[k].prog[2] = enc(3'b000, 3); vt[k].prog[3] = enc(3'b001, 1);
      vt[k].acc = 8'd8; vt[k].pc = 8'd5;
    end
    vt[0].cyc = 10;
    vt[1].iw = 3; vt[1].cyc = 25;
    // signed overflow: 31 * 5 = 155
    vt[2].prog[0] = enc(3'b000, 31); vt[2].prog[1] = enc(3'b011, 2);
    for (int j = 2; j < 6; j++) vt[2].prog[j] = enc(3'b001, 2);
    vt[2].prog[6] = enc(3'b000, 1);
    vt[2].ovf = 1;
`ifdef MIPS_MC_OVF_TRAP_EN
    vt[2].acc = 8'h9B; vt[2].pc = 8'd6; vt[2].cyc = 12;
`else
    vt[2].acc = 8'h01; vt[2].pc = 8'd8; vt[2].cyc = 16;
`endif
    // BZ taken: 1 -> 7, BZ -2 at 7 -> 6 (HALT)
    vt[3].prog[0] = enc(3'b000, 0); vt[3].prog[1] = enc(3'b110, 5);
    vt[3].prog[7] = enc(3'b110, -2);
    vt[3].acc = 8'd0; vt[3].pc = 8'd7; vt[3].cyc = 8;
    // BZ not taken at 7 with acc=1 -> falls through to 8
    for (int j = 0; j < 7; j++) vt[4].prog[j] = enc(3'b000, 1);
    vt[4].prog[7] = enc(3'b110, -2);
    vt[4].acc = 8'd1; vt[4].pc = 8'd9; vt[4].cyc = 18;
    // store 0x5A to R3=0x10, clear acc, load it back
    for (int k = 5; k < 7; k++) begin
      vt[k].prog[0] = enc(3'b000, 16); vt[k].prog[1] = enc(3'b011, 3);
      vt[k].prog[2] = enc(3'b000, 30); vt[k].prog[3] = enc(3'b011, 4);
      vt[k].prog[4] = enc(3'b001, 4);  vt[k].prog[5] = enc(3'b001, 4);
      vt[k].prog[6] = enc(3'b101, 3);  vt[k].prog[7] = enc(3'b000, 0);
      vt[k].prog[8] = enc(3'b100, 3);
      vt[k].acc = 8'h5A; vt[k].pc = 8'd10; vt[k].is_mem = 1;
    end
    vt[5].cyc = 22;
    vt[6].iw = 1; vt[6].dwt = 2; vt[6].cyc = 36;

    // ---- reset state ----
    clear_imem();
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    #12;
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_acc", 32'(acc_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", 32'(imem_addr), 0);
    do_reset();
    #1;
    chk("first_fetch_req", 32'(imem_req), 1);
    chk("first_fetch_addr", 32'(imem_addr), 0);

    // ---- table ----
    for (int k = 0; k < 7; k++) begin
      clear_imem();
      for (int j = 0; j < 12; j++) imem[j] = vt[k].prog[j];
      for (int i = 0; i < 256; i++) dmem[i] = '0;
      imem_wait = vt[k].iw; dmem_wait = vt[k].dwt;
      do_reset();
      run(400, cyc, ok);
      chk($sformatf("v%0d_halted", k), 32'(ok), 1);
      chk($sformatf("v%0d_cycles", k), 32'(cyc), 32'(vt[k].cyc));
      chk($sformatf("v%0d_acc", k), 32'(acc_out), 32'(vt[k].acc));
      chk($sformatf("v%0d_pc", k), 32'(imem_addr), 32'(vt[k].pc));
      chk($sformatf("v%0d_ovf", k), 32'(overflow), 32'(vt[k].ovf));
      chk($sformatf("v%0d_overlap", k), 32'(viol_overlap), 0);
      chk($sformatf("v%0d_stable", k), 32'(viol_stable), 0);
      if (vt[k].is_mem) begin
        chk($sformatf("v%0d_st_count", k), 32'(st_count), 1);
        chk($sformatf("v%0d_st_addr", k), 32'(st_addr), 32'h10);
        chk($sformatf("v%0d_st_data", k), 32'(st_data), 32'h5A);
      end
      // halted core stays frozen with no requests
      a0 = acc_out; p0 = imem_addr;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_frozen", k),
          {22'd0, imem_req, dmem_req, acc_out},
          {22'd0, 1'b0, 1'b0, a0});
      chk($sformatf("v%0d_frozen_pc", k), 32'(imem_addr), 32'(p0));
    end

    // asynchronous reset clears sticky overflow and halted (after v6 the core is halted)
    rst = 0; #1;
    chk("arst_halted", 32'(halted), 0);
    chk("arst_acc", 32'(acc_out), 0);

    // ---- BZ wrap: BZ -2 at 0 -> 0xFF, BZ +1 at 0xFF -> 0x01 ----
    clear_imem();
    imem[0] = enc(3'b110, -2); imem[255] = enc(3'b110, 1);
    imem_wait = 0; dmem_wait = 0;
    do_reset();
    run(100, cyc, ok);
    chk("wrap_halted", 32'(ok), 1);
    chk("wrap_pc", 32'(imem_addr), 2);
    chk("wrap_cycles", 32'(cyc), 6);

    // ---- reset during a stalled store ----
    clear_imem();
    imem[0] = enc(3'b000, 5); imem[1] = enc(3'b101, 0);
    dmem_wait = 1000;
    do_reset();
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(posedge clk); #1;
      if (dmem_req) ok = 1;
    end
    chk("stall_st_reached", 32'(ok), 1);
    chk("stall_st_we", 32'(dmem_we), 1);
    chk("stall_st_wdata", 32'(dmem_wdata), 5);
    #2; rst = 0; #1;
    chk("arst_dmem_req", {30'd0, dmem_req, dmem_we}, 0);
    chk("arst_imem_req", 32'(imem_req), 0);
    dmem_wait = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1; #1;
    chk("rerun_fetch", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'd0});
    chk("rerun_acc", 32'(acc_out), 0);
    st_count = 0;
    run(100, cyc, ok);
    chk("rerun_halted", 32'(ok), 1);
    chk("rerun_cycles", 32'(cyc), 7);
    chk("rerun_st_count", 32'(st_count), 1);

    // ---- random programs vs reference model ----
    for (int it = 0; it < 25; it++) begin
      clear_imem();
      for (int j = 0; j < 24; j++) begin
        r = $urandom_range(0, 6);
        if (r == 6) imem[j] = enc(3'b110, $urandom_range(0, 7));
        else        imem[j] = enc(3'(r), $urandom_range(0, 63));
      end
      for (int i = 0; i < 256; i++) begin
        dmem[i] = 8'($urandom);
        m_dmem[i] = dmem[i];
      end
      imem_wait = $urandom_range(0, 2); dmem_wait = $urandom_range(0, 2);
      model(imem_wait, dmem_wait, macc, mpc, movf, mhalt, mcyc);
      do_reset();
      run(3000, cyc, ok);
      chk($sformatf("rnd%0d_halted", it), 32'(ok), 32'(mhalt));
      chk($sformatf("rnd%0d_cycles", it), 32'(cyc), 32'(mcyc));
      chk($sformatf("rnd%0d_acc", it), 32'(acc_out), 32'(macc));
      chk($sformatf("rnd%0d_pc", it), 32'(imem_addr), 32'(mpc));
      chk($sformatf("rnd%0d_ovf", it), 32'(overflow), 32'(movf));
      mm = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== m_dmem[i]) mm++;
      chk($sformatf("rnd%0d_dmem", it), 32'(mm), 0);
      chk($sformatf("rnd%0d_protocol", it), 32'(viol_overlap + viol_stable), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc.md
MIPS_MC -- requirements
Module: mips_mc

Interface
REQ-001 Parameter DW, default 8, data/accumulator/register width (8..32).
REQ-002 Parameter PCW, default 8, program-counter and address width.
REQ-003 Parameter IW, fixed 9, instruction width: opcode inst[8:6], field inst[5:0].
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 imem_req  out  1  instruction fetch request; imem_addr  out  PCW  fetch address (= pc).
REQ-007 imem_valid  in  1  fetch complete; imem_inst  in  IW  fetched word, sampled when imem_req && imem_valid.
REQ-008 dmem_req  out  1, dmem_we  out  1, dmem_addr  out  PCW, dmem_wdata  out  DW  data access.
REQ-009 dmem_valid  in  1  access complete; dmem_rdata  in  DW  load data, sampled when dmem_req && dmem_valid.
REQ-010 acc_out  out  DW  accumulator; overflow  out  1  sticky signed overflow; halted  out  1  core stopped.

Function
REQ-011 FSM states FETCH, EXEC, MEM, HALT; no other states reachable.
REQ-012 FETCH: imem_req=1, imem_addr=pc; on edge with imem_valid, latch instruction, pc<=pc+1 (wraps modulo 2^PCW), go EXEC; otherwise hold.
REQ-013 EXEC, one cycle, by opcode: 000 LDI acc<=sext(field); 001 ADD acc<=acc+R[f[2:0]]; 010 SUB acc<=acc-R[f[2:0]]; 011 MOV f[3]=0: R[f[2:0]]<=acc, f[3]=1: acc<=R[f[2:0]]; 110 BZ if acc==0 then pc<=pc+sext(field) (relative to incremented pc, wraps); 111 HALT. ALU/MOV/BZ go FETCH; HALT goes HALT.
REQ-014 Opcodes 100 LD, 101 ST go MEM: dmem_req=1, dmem_addr=R[f[2:0]][PCW-1:0] (zero-extended if DW<PCW), dmem_we=1 for ST, dmem_wdata=acc.
REQ-015 MEM: hold all dmem outputs stable until dmem_valid edge; LD then acc<=dmem_rdata; go FETCH.
REQ-016 imem_req and dmem_req never high in the same cycle; dmem_we=0 whenever dmem_req=0.
REQ-017 ADD/SUB are DW-bit wrap-around; signed overflow sets overflow, cleared only by reset.
REQ-018 Zero-wait latency: ALU/BZ/MOV 2 cycles, LD/ST 3 cycles per instruction.
REQ-019 HALT: halted=1, no requests, state frozen until reset.

Reset
REQ-020 While rst=0: state=FETCH, pc=0, acc=0, R[0..7]=0, overflow=0, halted=0, imem_req and dmem_req forced 0 asynchronously, including mid-MEM; pending access is abandoned.
REQ-021 First fetch, at address 0, requested in the first cycle after rst deasserts.

Configuration
REQ-022 Macro MIPS_MC_OVF_TRAP_EN defined: a signed-overflowing ADD/SUB still writes acc, then EXEC goes HALT instead of FETCH (halted=1, pc points past the faulting instruction).
REQ-023 Macro undefined: overflow is a sticky flag only; execution continues.

Structure
REQ-024 Shared package mips_pkg: opcode constants, FSM state encoding, IW, field bit positions.
REQ-025 One sub-module mips_regfile: 8 x DW, one async-read port per read, one sync write, reset to 0.
REQ-026 ALU and FSM inline in mips_mc; no other sub-modules.

Verification
REQ-027 Zero-wait memory, program LDI 5; MOV R1<-acc; LDI 3; ADD R1; HALT -> acc_out=8, halted=1 after 10 cycles, pc=5.
REQ-028 imem_valid delayed 3 cycles per fetch -> imem_addr and imem_req stable during wait; same final acc=8.
REQ-029 DW=8: LDI 31, MOV R2, ADD R2 x3 (acc=124), ADD R2 -> acc=0x9B, overflow=1; with MIPS_MC_OVF_TRAP_EN, halted=1 right after that ADD, without it the next instruction is fetched.
REQ-030 R3=0x10, acc=0x5A, ST R3 then LDI 0, LD R3 (mem returns 0x5A) -> dmem_we=1 addr 0x10 wdata 0x5A, then acc=0x5A; dmem_req never overlaps imem_req.
REQ-031 acc=0, BZ -2 at pc=7 -> next fetch address 6; acc=1 -> next fetch address 8; BZ +1 at pc=0xFF wraps to 0x01.
REQ-032 rst pulled low during a stalled ST (dmem_valid=0) -> dmem_req drops in the same cycle; after release first fetch at address 0, acc=0.
